rdmap_hdr_gen: RTL and testbench

- Transmit-side RDMAP header generator. It is the counterpart of the receive header classifier.
- Arbitrates five request sources (ACK, WR_DONE, RD_DONE, REQ, SEND) and segments each SEND message into per-segment headers.
- Presents one 56-bit header per slot to DDP over a valid/ready handshake.
- Writes the per-TID segment count into the send dataNum table, which the receive side reads back.

---
 rtl/rdmap_hdr_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_rdmap_hdr_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdmap_hdr_gen.sv
`default_nettype none
// ============================================================================
// Module   : rdmap_hdr_gen
// Purpose  : Transmit-side RDMAP header generator. Arbitrates ACK, WR_DONE,
//            RD_DONE, REQ and SEND request sources with strict priority. It
//            splits each SEND message into per-segment headers and presents
//            one 56-bit header per slot to DDP over a valid/ready handshake.
//            On each first-segment grant it writes the message segment count
//            into the send dataNum table.
// Ports    : clock, reset           - core clock, async active-high reset
//            ackReq*/wrDone*/rdDone*/req* - control request sources
//            sendReq*               - SEND message source
//            rdmapHdrValid/rdmapControl/rdmapHeader, ddpHdrReady - DDP side
//            dataNumWr/dataNumWrAddr/dataNumWrData - dataNum table write
//            sendBusy, errSegNum    - status
// Options  : RDMAP_HDR_GEN_FAIR_EN  - when defined, a SEND segment is forced
//            after STARVE_LIMIT consecutive control grants while SENDING.
// Revision : 1.0 - initial release
// ============================================================================
module rdmap_hdr_gen #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ackReqValid,
  input  logic [27:0] ackReqInfo,
  output logic        ackReqReady,
  input  logic        wrDoneValid,
  input  logic [7:0]  wrDoneTid,
  output logic        wrDoneReady,
  input  logic        rdDoneValid,
  input  logic [7:0]  rdDoneTid,
  output logic        rdDoneReady,
  input  logic        reqValid,
  input  logic [55:0] reqInfo,
  output logic        reqReady,
  input  logic        sendReqValid,
  input  logic [7:0]  sendReqTid,
  input  logic [2:0]  sendReqNum,
  input  logic [31:0] sendReqInfo,
  output logic        sendReqReady,
  output logic        rdmapHdrValid,
  output logic [7:0]  rdmapControl,
  output logic [55:0] rdmapHeader,
  input  logic        ddpHdrReady,
  output logic        dataNumWr,
  output logic [7:0]  dataNumWrAddr,
  output logic [2:0]  dataNumWrData,
  output logic        sendBusy,
  output logic        errSegNum
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] SENDING = 1'b1;

  localparam logic [7:0] c_OP_ACK  = 8'h07;
  localparam logic [7:0] c_OP_WR   = 8'h06;
  localparam logic [7:0] c_OP_RD   = 8'h04;
  localparam logic [7:0] c_OP_REQ  = 8'h03;
  localparam logic [7:0] c_OP_SEND = 8'h00;

  generate
    if (STARVE_LIMIT < 1) begin : g_badStarveLimit
      $error("STARVE_LIMIT must be at least 1");
    end
  endgenerate

  logic [0:0]  r_state;
  logic [7:0]  r_tid;
  logic [2:0]  r_segNum;
  logic [2:0]  r_segIdx;
  logic [31:0] r_info;
  logic        r_hdrValid;
  logic [7:0]  r_control;
  logic [55:0] r_header;
  logic        r_errSegNum;

  logic        w_sending;
  logic        w_slotFree;
  logic        w_forceSeg;
  logic        w_ctrlAllowed;
  logic        w_ctrlPending;
  logic        w_grantAck;
  logic        w_grantWr;
  logic        w_grantRd;
  logic        w_grantReq;
  logic        w_grantSeg;
  logic        w_grantAny;
  logic [2:0]  w_inNum;
  logic [2:0]  w_nextIdx;
  logic [2:0]  w_segNumOut;
  logic        w_lastSeg;
  logic [7:0]  w_ctl;
  logic [55:0] w_hdr;

  assign w_sending = (r_state == SENDING);

  // Gating with reset keeps every combinational output at 0 while reset is
  // asserted, not just the registered ones.
  assign w_slotFree    = !reset && (!r_hdrValid || ddpHdrReady);
  assign w_ctrlAllowed = w_slotFree && !w_forceSeg;
  assign w_ctrlPending = ackReqValid || wrDoneValid || rdDoneValid || reqValid;

  assign w_grantAck = w_ctrlAllowed && ackReqValid;
  assign w_grantWr  = w_ctrlAllowed && wrDoneValid && !ackReqValid;
  assign w_grantRd  = w_ctrlAllowed && rdDoneValid && !ackReqValid && !wrDoneValid;
  assign w_grantReq = w_ctrlAllowed && reqValid && !ackReqValid && !wrDoneValid
                      && !rdDoneValid;
  // While SENDING the source keeps sendReqValid high, so only the control
  // sources (or the fairness override) decide whether a segment goes out.
  assign w_grantSeg = w_slotFree && (w_sending ? (w_forceSeg || !w_ctrlPending)
                                               : (sendReqValid && !w_ctrlPending));
  assign w_grantAny = w_grantAck || w_grantWr || w_grantRd || w_grantReq || w_grantSeg;

  // A zero segment count is treated as a single-segment message.
  assign w_inNum     = (sendReqNum == 3'd0) ? 3'd1 : sendReqNum;
  assign w_nextIdx   = w_sending ? (r_segIdx + 3'd1) : 3'd1;
  assign w_segNumOut = w_sending ? r_segNum : w_inNum;
  assign w_lastSeg   = (w_nextIdx == w_segNumOut);

`ifdef RDMAP_HDR_GEN_FAIR_EN
  localparam int c_CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic [c_CNT_W-1:0] r_starveCnt;
  logic               w_grantCtrl;

  assign w_grantCtrl = w_grantAck || w_grantWr || w_grantRd || w_grantReq;

  // Counts back-to-back control grants during a SEND; it saturates at the
  // limit because reaching it blocks further control grants.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starveCnt <= '0;
    end else if (!w_sending || w_grantSeg) begin
      r_starveCnt <= '0;
    end else if (w_grantCtrl) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  assign w_forceSeg = w_sending && (r_starveCnt == c_LIMIT);
`else
  assign w_forceSeg = 1'b0;
`endif

  always_comb begin
    w_ctl = 8'h00;
    w_hdr = 56'd0;
    if (w_grantAck) begin
      w_ctl = c_OP_ACK;
      w_hdr = {ackReqInfo[27:20], 28'd0, ackReqInfo[19:0]};
    end else if (w_grantWr) begin
      w_ctl = c_OP_WR;
      w_hdr = {wrDoneTid, 48'd0};
    end else if (w_grantRd) begin
      w_ctl = c_OP_RD;
      w_hdr = {rdDoneTid, 48'd0};
    end else if (w_grantReq) begin
      w_ctl = c_OP_REQ;
      w_hdr = reqInfo;
    end else if (w_grantSeg) begin
      w_ctl = c_OP_SEND;
      w_hdr = w_sending ? {r_tid, w_nextIdx, w_segNumOut, 10'd0, r_info}
                        : {sendReqTid, w_nextIdx, w_segNumOut, 10'd0, sendReqInfo};
    end
  end

  // Output slot: loaded on a grant, otherwise held until DDP takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hdrValid <= 1'b0;
      r_control  <= 8'h00;
      r_header   <= 56'd0;
    end else if (w_grantAny) begin
      r_hdrValid <= 1'b1;
      r_control  <= w_ctl;
      r_header   <= w_hdr;
    end else if (ddpHdrReady) begin
      r_hdrValid <= 1'b0;
    end
  end

  // Segmentation state. Message fields are captured only on the first
  // segment; later segments replay the captured copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tid       <= 8'h00;
      r_segNum    <= 3'd0;
      r_segIdx    <= 3'd0;
      r_info      <= 32'd0;
      r_errSegNum <= 1'b0;
    end else if (w_grantSeg) begin
      if (!w_sending) begin
        r_tid    <= sendReqTid;
        r_segNum <= w_inNum;
        r_info   <= sendReqInfo;
        if (sendReqNum == 3'd0) begin
          r_errSegNum <= 1'b1;
        end
      end
      if (w_lastSeg) begin
        r_state  <= IDLE;
        r_segIdx <= 3'd0;
      end else begin
        r_state  <= SENDING;
        r_segIdx <= w_nextIdx;
      end
    end
  end

  assign ackReqReady   = w_grantAck;
  assign wrDoneReady   = w_grantWr;
  assign rdDoneReady   = w_grantRd;
  assign reqReady      = w_grantReq;
  assign sendReqReady  = w_grantSeg && w_lastSeg;
  assign dataNumWr     = w_grantSeg && !w_sending;
  assign dataNumWrAddr = dataNumWr ? sendReqTid : 8'h00;
  assign dataNumWrData = dataNumWr ? w_inNum : 3'd0;
  assign rdmapHdrValid = r_hdrValid;
  assign rdmapControl  = r_control;
  assign rdmapHeader   = r_header;
  assign sendBusy      = w_sending;
  assign errSegNum     = r_errSegNum;

endmodule
`default_nettype wire

// File: tb/tb_rdmap_hdr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdmap_hdr_gen
// Purpose  : Self-checking bench for rdmap_hdr_gen. Directed stimulus drives
//            the request sources; a scoreboard of expected headers (built
//            from the header format rules) is compared against every header
//            DDP accepts, alongside stall-stability and ready checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rdmap_hdr_gen;
`ifdef RDMAP_HDR_GEN_FAIR_EN
  localparam int LIMIT = 1;
`else
  localparam int LIMIT = 4;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ackReqValid;
  logic [27:0] ackReqInfo;
  logic        ackReqReady;
  logic        wrDoneValid;
  logic [7:0]  wrDoneTid;
  logic        wrDoneReady;
  logic        rdDoneValid;
  logic [7:0]  rdDoneTid;
  logic        rdDoneReady;
  logic        reqValid;
  logic [55:0] reqInfo;
  logic        reqReady;
  logic        sendReqValid;
  logic [7:0]  sendReqTid;
  logic [2:0]  sendReqNum;
  logic [31:0] sendReqInfo;
  logic        sendReqReady;
  logic        rdmapHdrValid;
  logic [7:0]  rdmapControl;
  logic [55:0] rdmapHeader;
  logic        ddpHdrReady;
  logic        dataNumWr;
  logic [7:0]  dataNumWrAddr;
  logic [2:0]  dataNumWrData;
  logic        sendBusy;
  logic        errSegNum;

  rdmap_hdr_gen #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .ackReqValid(ackReqValid), .ackReqInfo(ackReqInfo), .ackReqReady(ackReqReady),
    .wrDoneValid(wrDoneValid), .wrDoneTid(wrDoneTid), .wrDoneReady(wrDoneReady),
    .rdDoneValid(rdDoneValid), .rdDoneTid(rdDoneTid), .rdDoneReady(rdDoneReady),
    .reqValid(reqValid), .reqInfo(reqInfo), .reqReady(reqReady),
    .sendReqValid(sendReqValid), .sendReqTid(sendReqTid), .sendReqNum(sendReqNum),
    .sendReqInfo(sendReqInfo), .sendReqReady(sendReqReady),
    .rdmapHdrValid(rdmapHdrValid), .rdmapControl(rdmapControl),
    .rdmapHeader(rdmapHeader), .ddpHdrReady(ddpHdrReady),
    .dataNumWr(dataNumWr), .dataNumWrAddr(dataNumWrAddr), .dataNumWrData(dataNumWrData),
    .sendBusy(sendBusy), .errSegNum(errSegNum)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass   = 0;

  logic [63:0] expQ[$];
  logic [10:0] dnLog[$];
  int          accCyc[$];
  int          accCnt = 0;
  int          cyc = 0;
  int          ackRdyCnt = 0;
  int          sendRdyCnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Header formats, one per opcode.
  function automatic logic [63:0] hAck(input logic [7:0] tid, input logic [19:0] q);
    return {8'h07, tid, 28'd0, q};
  endfunction
  function automatic logic [63:0] hWr(input logic [7:0] tid);
    return {8'h06, tid, 48'd0};
  endfunction
  function automatic logic [63:0] hReq(input logic [55:0] info);
    return {8'h03, info};
  endfunction
  function automatic logic [63:0] hSeg(input logic [7:0] tid, input logic [2:0] idx,
                                       input logic [2:0] num, input logic [31:0] info);
    return {8'h00, tid, idx, num, 10'd0, info};
  endfunction

  function automatic logic [127:0] allOutputs();
    return 128'({rdmapHdrValid, rdmapControl, rdmapHeader, ackReqReady, wrDoneReady,
                 rdDoneReady, reqReady, sendReqReady, dataNumWr, dataNumWrAddr,
                 dataNumWrData, sendBusy, errSegNum});
  endfunction

  // Compare process: every accepted header against the scoreboard, stall
  // stability and quiet readies while the slot is blocked.
  logic        prevStall = 1'b0;
  logic [63:0] prevOut   = 64'd0;
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall)
          check("hold_stable", 128'({rdmapHdrValid, rdmapControl, rdmapHeader}),
                128'({1'b1, prevOut}));
        if (rdmapHdrValid && !ddpHdrReady)
          check("stall_readies", 128'({ackReqReady, wrDoneReady, rdDoneReady, reqReady,
                                       sendReqReady, dataNumWr}), 128'(0));
        if (rdmapHdrValid && ddpHdrReady) begin
          accCnt++;
          accCyc.push_back(cyc);
          if (expQ.size() == 0) begin
            nChecks++;
            $display("FAIL unexpected_header: got %0h expected none",
                     {rdmapControl, rdmapHeader});
          end else begin
            check("header", 128'({rdmapControl, rdmapHeader}), 128'(expQ.pop_front()));
          end
        end
        if (ackReqReady)  ackRdyCnt++;
        if (sendReqReady) sendRdyCnt++;
        if (dataNumWr)    dnLog.push_back({dataNumWrAddr, dataNumWrData});
        prevStall = rdmapHdrValid && !ddpHdrReady;
        prevOut   = {rdmapControl, rdmapHeader};
      end
    end
  end

  task automatic timeoutFail(input string name);
    nChecks++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic doAck(input logic [7:0] tid, input logic [19:0] q);
    bit seen = 0;
    ackReqInfo = {tid, q};
    ackReqValid = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (ackReqReady) seen = 1;
    end
    if (!seen) timeoutFail("ack_wait");
    @(posedge clock); #1;
    ackReqValid = 1'b0;
  endtask

  task automatic doWr(input logic [7:0] tid);
    bit seen = 0;
    wrDoneTid = tid;
    wrDoneValid = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (wrDoneReady) seen = 1;
    end
    if (!seen) timeoutFail("wr_wait");
    @(posedge clock); #1;
    wrDoneValid = 1'b0;
  endtask

  task automatic doSend(input logic [7:0] tid, input logic [2:0] num, input logic [31:0] info);
    bit seen = 0;
    bit aborted = 0;
    sendReqTid = tid;
    sendReqNum = num;
    sendReqInfo = info;
    sendReqValid = 1'b1;
    for (int i = 0; i < 100 && !seen && !aborted; i++) begin
      @(negedge clock);
      if (reset) aborted = 1;
      else if (sendReqReady) seen = 1;
    end
    if (aborted) begin
      sendReqValid = 1'b0;
    end else begin
      if (!seen) timeoutFail("send_wait");
      @(posedge clock); #1;
      sendReqValid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    check(name, 128'(expQ.size()), 128'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dnBase;
    int accBase;
    reset = 1'b1;
    ackReqValid = 0; ackReqInfo = '0; wrDoneValid = 0; wrDoneTid = '0;
    rdDoneValid = 0; rdDoneTid = '0; reqValid = 0; reqInfo = '0;
    sendReqValid = 0; sendReqTid = '0; sendReqNum = '0; sendReqInfo = '0;
    ddpHdrReady = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_outputs", allOutputs(), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", allOutputs(), 128'(0));
    @(posedge clock); #1;

    // Single ACK: header one cycle after the grant, ready for exactly one cycle
    base = ackRdyCnt;
    expQ.push_back(hAck(8'h5A, 20'h12345));
    doAck(8'h5A, 20'h12345);
    @(negedge clock);
    check("t1_valid_ctl", 128'({rdmapHdrValid, rdmapControl}), 128'({1'b1, 8'h07}));
    check("t1_header", 128'(rdmapHeader), 128'(56'h5A000000012345));
    #1;
    waitDrain("t1_drain");
    check("t1_ack_ready_pulses", 128'(ackRdyCnt - base), 128'(1));

    // Three-segment SEND, back to back
    base = sendRdyCnt; dnBase = dnLog.size(); accBase = accCnt;
    expQ.push_back(hSeg(8'h10, 3'd1, 3'd3, 32'hDEADBEEF));
    expQ.push_back(hSeg(8'h10, 3'd2, 3'd3, 32'hDEADBEEF));
    expQ.push_back(hSeg(8'h10, 3'd3, 3'd3, 32'hDEADBEEF));
    doSend(8'h10, 3'd3, 32'hDEADBEEF);
    waitDrain("t2_drain");
    check("t2_datanum_writes", 128'(dnLog.size() - dnBase), 128'(1));
    if (dnLog.size() > dnBase)
      check("t2_datanum_entry", 128'(dnLog[dnBase]), 128'({8'h10, 3'd3}));
    check("t2_send_ready_pulses", 128'(sendRdyCnt - base), 128'(1));
    if (accCyc.size() >= accBase + 3)
      check("t2_back_to_back", 128'(accCyc[accBase+2] - accCyc[accBase]), 128'(2));
    check("t2_not_busy", 128'(sendBusy), 128'(0));

    // SEND of 4 preempted by ACK and WR_DONE after segment 1
    expQ.push_back(hSeg(8'h21, 3'd1, 3'd4, 32'h01234567));
    expQ.push_back(hAck(8'h77, 20'hABCDE));
`ifdef RDMAP_HDR_GEN_FAIR_EN
    expQ.push_back(hSeg(8'h21, 3'd2, 3'd4, 32'h01234567));
    expQ.push_back(hWr(8'h88));
`else
    expQ.push_back(hWr(8'h88));
    expQ.push_back(hSeg(8'h21, 3'd2, 3'd4, 32'h01234567));
`endif
    expQ.push_back(hSeg(8'h21, 3'd3, 3'd4, 32'h01234567));
    expQ.push_back(hSeg(8'h21, 3'd4, 3'd4, 32'h01234567));
    fork
      doSend(8'h21, 3'd4, 32'h01234567);
      begin
        @(posedge clock); #1;
        fork
          doAck(8'h77, 20'hABCDE);
          doWr(8'h88);
        join
      end
    join
    waitDrain("t3_drain");

    // DDP stall with a REQ header held, then REQ and ACK back to back
    expQ.push_back(hReq(56'h0123456789ABCD));
    expQ.push_back(hAck(8'h3C, 20'h0F0F0));
    ddpHdrReady = 1'b0;
    reqInfo = 56'h0123456789ABCD;
    reqValid = 1'b1;
    @(negedge clock);
    check("t4_req_ready", 128'(reqReady), 128'(1));
    @(posedge clock); #1;
    reqValid = 1'b0;
    ackReqInfo = {8'h3C, 20'h0F0F0};
    ackReqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_stall_hdr", 128'({rdmapHdrValid, rdmapControl, rdmapHeader}),
            128'({1'b1, 8'h03, 56'h0123456789ABCD}));
      check("t4_stall_ack_ready", 128'(ackReqReady), 128'(0));
    end
    @(posedge clock); #1;
    ddpHdrReady = 1'b1;
    @(negedge clock);
    check("t4_ack_ready_on_release", 128'(ackReqReady), 128'(1));
    @(posedge clock); #1;
    ackReqValid = 1'b0;
    @(negedge clock);
    check("t4_ack_back_to_back", 128'({rdmapHdrValid, rdmapControl}), 128'({1'b1, 8'h07}));
    #1;
    waitDrain("t4_drain");

    // Zero segment count is treated as one and flagged
    check("t5_err_before", 128'(errSegNum), 128'(0));
    dnBase = dnLog.size();
    expQ.push_back(hSeg(8'h33, 3'd1, 3'd1, 32'hCAFEF00D));
    doSend(8'h33, 3'd0, 32'hCAFEF00D);
    waitDrain("t5_drain");
    check("t5_err_set", 128'(errSegNum), 128'(1));
    if (dnLog.size() > dnBase)
      check("t5_datanum_entry", 128'(dnLog[dnBase]), 128'({8'h33, 3'd1}));
    else
      check("t5_datanum_writes", 128'(dnLog.size() - dnBase), 128'(1));
    check("t5_not_busy", 128'(sendBusy), 128'(0));
    repeat (3) @(posedge clock); #1;
    check("t5_err_sticky", 128'(errSegNum), 128'(1));

    // Reset after segment 2 of 5 abandons the message
    base = sendRdyCnt;
    expQ.push_back(hSeg(8'h44, 3'd1, 3'd5, 32'h55AA55AA));
    expQ.push_back(hSeg(8'h44, 3'd2, 3'd5, 32'h55AA55AA));
    fork
      doSend(8'h44, 3'd5, 32'h55AA55AA);
      begin
        bit got = 0;
        accBase = accCnt;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clock); #1;
          if (accCnt >= accBase + 2) got = 1;
        end
        if (!got) timeoutFail("t6_seg2_wait");
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", allOutputs(), 128'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t6_no_more_segments", 128'(rdmapHdrValid), 128'(0));
    end
    check("t6_idle", 128'(sendBusy), 128'(0));
    check("t6_no_send_ready", 128'(sendRdyCnt - base), 128'(0));
    check("t6_err_cleared", 128'(errSegNum), 128'(0));
    check("t6_queue_empty", 128'(expQ.size()), 128'(0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
